// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   size_e          : request size encodings (byte, half, word, illegal)
//   state_e         : sequencing FSM states
//   lsu_req_t       : request fields latched on the accept edge
//   is_misaligned() : illegal size or a half/word access off its natural boundary
package lsu_pkg;

   localparam logic [15:0] MMIO_REGION_DEFAULT = 16'hffff;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'b00,
      SIZE_HALF    = 2'b01,
      SIZE_ILLEGAL = 2'b10,
      SIZE_WORD    = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic        we;
      size_e       size;
      logic        sign_ext;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
      case (size)
         SIZE_ILLEGAL: return 1'b1;
         SIZE_HALF:    return offset[0];
         SIZE_WORD:    return offset != 2'b00;
         default:      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_ops.sv
// Big-endian byte-lane helpers for the load/store unit (purely combinational).
//   size, sign_ext, offset : access descriptor (offset = addr[1:0])
//   word                   : full memory word the access refers to
//   wdata                  : right-justified store data
//   load_data              : selected lane, zero- or sign-extended (word unchanged)
//   lane_data              : store data moved into its lane, all other bytes 0
//   merged_data            : word with only the target lane replaced by store data
module lsu_lane_ops
   import lsu_pkg::*;
(
   input  size_e       size,
   input  logic        sign_ext,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] lane_data,
   output logic [31:0] merged_data
);

   logic [4:0]  shift;
   logic [31:0] mask;
   logic [31:0] shifted;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
      shift = 5'd0;
      mask  = 32'hFFFF_FFFF;
      case (size)
         // Byte k sits at bits [31-8k:24-8k]: shift right by (3-k)*8, i.e. ~k * 8.
         SIZE_BYTE: begin
            shift = {~offset, 3'b000};
            mask  = 32'h0000_00FF << shift;
         end
         // Half at offset 0 is the upper half, offset 2 the lower half.
         SIZE_HALF: begin
            shift = {~offset[1], 4'b0000};
            mask  = 32'h0000_FFFF << shift;
         end
         default: begin
            shift = 5'd0;
            mask  = 32'hFFFF_FFFF;
         end
      endcase

      shifted = word >> shift;
      case (size)
         SIZE_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
         SIZE_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
         default:   load_data = word;
      endcase

      lane_data   = (wdata << shift) & mask;
      merged_data = (word & ~mask) | lane_data;
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a single-cycle data-memory word port.
//   clock, reset                 : rising-edge clock, synchronous active-low reset
//   req_*_in / req_ready_out     : request handshake (accepted in IDLE when valid)
//   resp_valid_out/rdata/err     : one-cycle completion pulse with load data or error flag
//   mem_*_out / mem_readdata_in  : word-wide memory port, read data returned in the same cycle
// Sub-word stores outside MMIO_REGION do read-modify-write; inside it they write
// the lane directly so a side-effecting serial register is never read.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter logic [15:0] MMIO_REGION = MMIO_REGION_DEFAULT
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid_in,
   output logic        req_ready_out,
   input  logic        req_we_in,
   input  logic [1:0]  req_size_in,
   input  logic        req_signed_in,
   input  logic [31:0] req_addr_in,
   input  logic [31:0] req_wdata_in,
   output logic        resp_valid_out,
   output logic [31:0] resp_rdata_out,
   output logic        resp_err_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_writedata_out,
   output logic        mem_re_out,
   output logic        mem_we_out,
   output logic [1:0]  mem_size_out,
   input  logic [31:0] mem_readdata_in
);

   state_e      state, state_next;
   lsu_req_t    req;
   logic        err_q;
   logic [31:0] captured;

   logic [31:0] load_data, lane_data, merged_data;
   logic        accept, req_err, req_mmio, latched_mmio, latched_word;

   assign accept       = (state == IDLE) && req_valid_in;
   assign req_err      = is_misaligned(size_e'(req_size_in), req_addr_in[1:0]);
   assign req_mmio     = req_addr_in[31:16] == MMIO_REGION;
   assign latched_mmio = req.addr[31:16] == MMIO_REGION;
   assign latched_word = req.size == SIZE_WORD;

   lsu_lane_ops u_lane_ops (
      .size        (req.size),
      .sign_ext    (req.sign_ext),
      .offset      (req.addr[1:0]),
      .word        (captured),
      .wdata       (req.wdata),
      .load_data   (load_data),
      .lane_data   (lane_data),
      .merged_data (merged_data)
   );

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         state    <= IDLE;
         req      <= '0;
         err_q    <= 1'b0;
         captured <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            req.we       <= req_we_in;
            req.size     <= size_e'(req_size_in);
            req.sign_ext <= req_signed_in;
            req.addr     <= req_addr_in;
            req.wdata    <= req_wdata_in;
            err_q        <= req_err;
         end
         if (state == RD) captured <= mem_readdata_in;
      end
   end

   always_comb begin
      state_next        = state;
      req_ready_out     = 1'b0;
      mem_re_out        = 1'b0;
      mem_we_out        = 1'b0;
      mem_addr_out      = 32'd0;
      mem_writedata_out = 32'd0;
      resp_valid_out    = 1'b0;
      resp_err_out      = 1'b0;
      resp_rdata_out    = 32'd0;
      case (state)
         IDLE: begin
            req_ready_out = 1'b1;
            if (req_valid_in) begin
               if (req_err)
                  state_next = DONE;
               else if (!req_we_in)
                  state_next = RD;
               else if (size_e'(req_size_in) == SIZE_WORD || req_mmio)
                  state_next = WR;
               else
                  state_next = RD;
            end
         end
         RD: begin
            // Strobes are gated by reset so an aborted access never reaches memory.
            mem_re_out   = reset;
            mem_addr_out = {req.addr[31:2], 2'b00};
            state_next   = req.we ? WR : DONE;
         end
         WR: begin
            mem_we_out        = reset;
            mem_addr_out      = {req.addr[31:2], 2'b00};
            mem_writedata_out = (latched_word || latched_mmio) ? lane_data : merged_data;
            state_next        = DONE;
         end
         DONE: begin
            resp_valid_out = reset;
            resp_err_out   = err_q;
            resp_rdata_out = (!req.we && !err_q) ? load_data : 32'd0;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign mem_size_out = 2'b11;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit. Inputs change 1 ns after the
// rising edge; outputs are checked at that point, strobes are tallied on falling edges.
module tb_load_store_unit;

   logic        clock;
   logic        reset;
   logic        req_valid_in, req_ready_out, req_we_in, req_signed_in;
   logic [1:0]  req_size_in;
   logic [31:0] req_addr_in, req_wdata_in;
   logic        resp_valid_out, resp_err_out;
   logic [31:0] resp_rdata_out;
   logic [31:0] mem_addr_out, mem_writedata_out, mem_readdata_in;
   logic        mem_re_out, mem_we_out;
   logic [1:0]  mem_size_out;

   int vectors    = 0;
   int miscompares = 0;
   int re_count   = 0;
   int we_count   = 0;
   int re_base, we_base;

   load_store_unit dut (
      .clock             (clock),
      .reset             (reset),
      .req_valid_in      (req_valid_in),
      .req_ready_out     (req_ready_out),
      .req_we_in         (req_we_in),
      .req_size_in       (req_size_in),
      .req_signed_in     (req_signed_in),
      .req_addr_in       (req_addr_in),
      .req_wdata_in      (req_wdata_in),
      .resp_valid_out    (resp_valid_out),
      .resp_rdata_out    (resp_rdata_out),
      .resp_err_out      (resp_err_out),
      .mem_addr_out      (mem_addr_out),
      .mem_writedata_out (mem_writedata_out),
      .mem_re_out        (mem_re_out),
      .mem_we_out        (mem_we_out),
      .mem_size_out      (mem_size_out),
      .mem_readdata_in   (mem_readdata_in)
   );

   // Static memory: one known word, everything else an address-derived pattern.
   assign mem_readdata_in = (mem_addr_out == 32'h1000_0010) ? 32'h8899_AABB
                                                            : (mem_addr_out ^ 32'h5A5A_5A5A);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (mem_re_out) re_count++;
      if (mem_we_out) we_count++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic request(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
      req_valid_in  = 1'b1;
      req_we_in     = we;
      req_size_in   = size;
      req_signed_in = sgn;
      req_addr_in   = addr;
      req_wdata_in  = wdata;
   endtask

   // After the accept edge, drop valid and scramble the request fields; the unit must ignore them.
   task automatic scramble();
      req_valid_in  = 1'b0;
      req_we_in     = ~req_we_in;
      req_size_in   = 2'b10;
      req_signed_in = ~req_signed_in;
      req_addr_in   = 32'hDEAD_BEE3;
      req_wdata_in  = 32'hCAFE_F00D;
   endtask

   // Sub-word load: accept, one RD, response two cycles after accept.
   task automatic sub_load(input string tag, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] exp_word_addr,
                           input logic [31:0] exp_rdata);
      re_base = re_count;
      request(1'b0, size, sgn, addr, 32'd0);
      check({tag, "_ready"}, {31'd0, req_ready_out}, 32'd1);
      tick();
      scramble();
      check({tag, "_re"}, {31'd0, mem_re_out}, 32'd1);
      check({tag, "_raddr"}, mem_addr_out, exp_word_addr);
      check({tag, "_early_valid"}, {31'd0, resp_valid_out}, 32'd0);
      tick();
      check({tag, "_valid"}, {31'd0, resp_valid_out}, 32'd1);
      check({tag, "_rdata"}, resp_rdata_out, exp_rdata);
      check({tag, "_err"}, {31'd0, resp_err_out}, 32'd0);
      tick();
      check({tag, "_valid_drop"}, {31'd0, resp_valid_out}, 32'd0);
      check({tag, "_re_count"}, re_count - re_base, 32'd1);
   endtask

   // Error request: straight to DONE, error flag with the pulse, no strobes.
   task automatic err_req(input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] addr);
      re_base = re_count;
      we_base = we_count;
      request(we, size, 1'b0, addr, 32'h1111_2222);
      tick();
      scramble();
      check({tag, "_valid"}, {31'd0, resp_valid_out}, 32'd1);
      check({tag, "_err"}, {31'd0, resp_err_out}, 32'd1);
      check({tag, "_rdata"}, resp_rdata_out, 32'd0);
      check({tag, "_maddr"}, mem_addr_out, 32'd0);
      tick();
      check({tag, "_ready"}, {31'd0, req_ready_out}, 32'd1);
      check({tag, "_strobes"}, (re_count - re_base) + (we_count - we_base), 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      req_valid_in = 1'b0; req_we_in = 1'b0; req_size_in = 2'b00; req_signed_in = 1'b0;
      req_addr_in = 32'd0; req_wdata_in = 32'd0;
      tick();
      tick();

      // Reset state
      check("rst_ready", {31'd0, req_ready_out}, 32'd1);
      check("rst_valid", {31'd0, resp_valid_out}, 32'd0);
      check("rst_err", {31'd0, resp_err_out}, 32'd0);
      check("rst_rdata", resp_rdata_out, 32'd0);
      check("rst_maddr", mem_addr_out, 32'd0);
      check("rst_strobes", {30'd0, mem_re_out, mem_we_out}, 32'd0);
      check("rst_msize", {30'd0, mem_size_out}, 32'd3);
      reset = 1'b1;
      tick();

      // Loads from 0x8899AABB
      sub_load("ldb_s", 2'b00, 1'b1, 32'h1000_0011, 32'h1000_0010, 32'hFFFF_FF99);
      sub_load("ldb_u", 2'b00, 1'b0, 32'h1000_0013, 32'h1000_0010, 32'h0000_00BB);
      sub_load("ldh_s", 2'b01, 1'b1, 32'h1000_0010, 32'h1000_0010, 32'hFFFF_8899);
      sub_load("ldh_u", 2'b01, 1'b0, 32'h1000_0012, 32'h1000_0010, 32'h0000_AABB);

      // Half store with read-modify-write
      re_base = re_count; we_base = we_count;
      request(1'b1, 2'b01, 1'b0, 32'h1000_0012, 32'h0000_1234);
      tick();
      scramble();
      check("sth_rd_re", {30'd0, mem_re_out, mem_we_out}, 32'd2);
      check("sth_rd_addr", mem_addr_out, 32'h1000_0010);
      tick();
      check("sth_wr_we", {30'd0, mem_re_out, mem_we_out}, 32'd1);
      check("sth_wr_addr", mem_addr_out, 32'h1000_0010);
      check("sth_wdata", mem_writedata_out, 32'h8899_1234);
      check("sth_wr_valid", {31'd0, resp_valid_out}, 32'd0);
      tick();
      check("sth_valid", {31'd0, resp_valid_out}, 32'd1);
      check("sth_rdata", resp_rdata_out, 32'd0);
      tick();
      check("sth_counts", {(re_count - re_base), (we_count - we_base)}, {32'd1, 32'd1});

      // Byte store into the serial region: no read, lane positioned, rest zero
      re_base = re_count; we_base = we_count;
      request(1'b1, 2'b00, 1'b0, 32'hFFFF_000C, 32'hFFFF_FF41);
      tick();
      scramble();
      check("mmio_we", {30'd0, mem_re_out, mem_we_out}, 32'd1);
      check("mmio_addr", mem_addr_out, 32'hFFFF_000C);
      check("mmio_wdata", mem_writedata_out, 32'h4100_0000);
      tick();
      check("mmio_valid", {31'd0, resp_valid_out}, 32'd1);
      tick();
      check("mmio_counts", {(re_count - re_base), (we_count - we_base)}, {32'd0, 32'd1});

      // Word store: direct write
      we_base = we_count;
      request(1'b1, 2'b11, 1'b0, 32'h0000_0200, 32'hA5A5_0F0F);
      tick();
      scramble();
      check("stw_wdata", mem_writedata_out, 32'hA5A5_0F0F);
      check("stw_we", {30'd0, mem_re_out, mem_we_out}, 32'd1);
      tick();
      check("stw_valid", {31'd0, resp_valid_out}, 32'd1);
      tick();
      check("stw_count", we_count - we_base, 32'd1);

      // Errors
      err_req("err_ldw", 1'b0, 2'b11, 32'h1000_0002);
      err_req("err_size", 1'b1, 2'b10, 32'h1000_0010);
      err_req("err_sth", 1'b1, 2'b01, 32'h1000_0011);

      // Reset during the read of a sub-word store
      we_base = we_count;
      request(1'b1, 2'b00, 1'b0, 32'h1000_0013, 32'h0000_0077);
      tick();
      scramble();
      check("abort_re_before", {31'd0, mem_re_out}, 32'd1);
      reset = 1'b0;
      #1;
      check("abort_re_gated", {30'd0, mem_re_out, mem_we_out}, 32'd0);
      tick();
      check("abort_ready", {31'd0, req_ready_out}, 32'd1);
      check("abort_valid", {31'd0, resp_valid_out}, 32'd0);
      reset = 1'b1;
      tick();
      check("abort_valid2", {31'd0, resp_valid_out}, 32'd0);
      tick();
      check("abort_we_count", we_count - we_base, 32'd0);

      // Three word loads with valid held high
      request(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b%0d_ready", i), {31'd0, req_ready_out}, 32'd1);
         tick();
         req_addr_in = req_addr_in + 32'd4;
         check($sformatf("b2b%0d_busy", i), {31'd0, req_ready_out}, 32'd0);
         tick();
         check($sformatf("b2b%0d_valid", i), {31'd0, resp_valid_out}, 32'd1);
         case (i)
            0: check("b2b0_rdata", resp_rdata_out, 32'h5A5A_5B5A);
            1: check("b2b1_rdata", resp_rdata_out, 32'h5A5A_5B5E);
            default: check("b2b2_rdata", resp_rdata_out, 32'h5A5A_5B52);
         endcase
         tick();
         check($sformatf("b2b%0d_gap", i), {31'd0, resp_valid_out}, 32'd0);
      end
      req_valid_in = 1'b0;
      tick();
      check("b2b_idle", {31'd0, req_ready_out}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
